mont_exp_ctrl: RTL

//  Left-to-right square-and-multiply controller computing result = a^e mod m; sits directly upstream of montgomery.

---
 rtl/mont_exp_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mont_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mont_exp_ctrl
// Description : Left-to-right square-and-multiply sequencer for a^e mod m.
//               Drives a Montgomery multiplier over a start/done handshake.
//               It does no arithmetic itself. All operands, and the result,
//               are in Montgomery form.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_exp_ctrl #(
    parameter int WIDTH = 381,
    parameter int EXP_W = 381
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [EXP_W-1:0] in_e,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_one,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_m,
    input  logic [WIDTH-1:0] mm_result,
    input  logic             mm_done
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] C_IDX_TOP = IDX_W'(EXP_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SQ    = 3'd1,
        S_SQ_W  = 3'd2,
        S_MUL   = 3'd3,
        S_MUL_W = 3'd4,
        S_NEXT  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_base;
    logic [WIDTH-1:0] r_m;
    logic [EXP_W-1:0] r_e;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_result;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; mm_done is only looked at in the two wait states
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SQ;
            S_SQ:    w_next = S_SQ_W;
            S_SQ_W:  if (mm_done) w_next = r_e[r_idx] ? S_MUL : S_NEXT;
            S_MUL:   w_next = S_MUL_W;
            S_MUL_W: if (mm_done) w_next = S_NEXT;
            S_NEXT:  w_next = (r_idx == '0) ? S_FIN : S_SQ;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, accumulator update, bit index walk and result capture.
    // result is loaded on the way into FIN so that it is valid during the
    // done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_base   <= '0;
            r_m      <= '0;
            r_e      <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= in_one;
                        r_base <= in_a;
                        r_m    <= in_m;
                        r_e    <= in_e;
                        r_idx  <= C_IDX_TOP;
                    end
                end
                S_SQ_W, S_MUL_W: begin
                    if (mm_done) r_acc <= mm_result;
                end
                S_NEXT: begin
                    if (r_idx == '0) r_result <= r_acc;
                    else             r_idx    <= r_idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Multiplier operands are held from the start cycle through the wait
    // state. acc changes only on the edge that leaves the wait state, so
    // the operands stay stable while the multiplier is working.
    always_comb begin
        mm_start = 1'b0;
        mm_a     = '0;
        mm_b     = '0;
        case (r_state)
            S_SQ, S_SQ_W: begin
                mm_start = (r_state == S_SQ);
                mm_a     = r_acc;
                mm_b     = r_acc;
            end
            S_MUL, S_MUL_W: begin
                mm_start = (r_state == S_MUL);
                mm_a     = r_acc;
                mm_b     = r_base;
            end
            default: ;
        endcase
    end

    assign result = r_result;
    assign mm_m   = r_m;
    assign done   = (r_state == S_FIN);
    assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire
